// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit: op-code and FSM state enums,
// plus the data width constant.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage, the muldiv unit and writeback.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] operandA_i;
    logic [XLEN-1:0] operandB_i;
    logic [4:0]      rd_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;
    logic            regwrite_o;

    modport master (
        output valid_i, op_i, operandA_i, operandB_i, rd_i, ready_i,
        input  ready_o, valid_o, result_o, rd_o, regwrite_o
    );

    modport slave (
        input  valid_i, op_i, operandA_i, operandB_i, rd_i, ready_i,
        output ready_o, valid_o, result_o, rd_o, regwrite_o
    );

endinterface

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per step,
// next-step quotient/remainder exposed combinationally so the caller can register the final pair.
module muldiv_div_core
    import muldiv_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o,
    output logic            last_o
);

    logic [XLEN-1:0] quot_q, rem_q, div_q;
    logic [4:0]      cnt_q;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {1'b0, div_q};
        // no borrow means the divisor fits into the shifted partial remainder
        if (!diff[XLEN]) begin
            rem_o  = diff[XLEN-1:0];
            quot_o = {quot_q[XLEN-2:0], 1'b1};
        end else begin
            rem_o  = shifted[XLEN-1:0];
            quot_o = {quot_q[XLEN-2:0], 1'b0};
        end
    end

    assign last_o = (cnt_q == 5'd31);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
        end else if (start_i) begin
            quot_q <= dividend_i;
            rem_q  <= '0;
            div_q  <= divisor_i;
            cnt_q  <= '0;
        end else if (step_i) begin
            quot_q <= quot_o;
            rem_q  <= rem_o;
            cnt_q  <= cnt_q + 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit with valid/ready request and writeback handshakes.
// Define MULDIV_MUL_EN to build the single-cycle multiplier; otherwise multiply ops return 0.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic    clk_i,
    input  logic    reset_i,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    state_e          state_q, state_d;
    op_e             op;
    logic            accept, is_div, is_signed, is_rem, div_zero, overflow, div_start;
    logic            sign_a, sign_b, fast_q, neg_q_q, neg_r_q, is_rem_q, div_last, valid;
    logic [XLEN-1:0] a, b, mag_a, mag_b, mul_res, fast_res;
    logic [XLEN-1:0] quot, rem, quot_fix, rem_fix, result_q;
    logic [4:0]      rd_q;

    assign op        = op_e'(bus.op_i);
    assign a         = bus.operandA_i;
    assign b         = bus.operandB_i;
    assign is_div    = bus.op_i[2];
    assign is_signed = (op == OP_DIV) || (op == OP_REM);
    assign is_rem    = (op == OP_REM) || (op == OP_REMU);
    assign sign_a    = is_signed & a[XLEN-1];
    assign sign_b    = is_signed & b[XLEN-1];
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;
    assign div_zero  = (b == '0);
    assign overflow  = is_signed & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    assign accept    = bus.valid_i & (state_q == S_IDLE);
    assign div_start = accept & is_div & ~div_zero & ~overflow;

`ifdef MULDIV_MUL_EN
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    always_comb begin
        a_ext   = (op == OP_MULH || op == OP_MULHSU) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        b_ext   = (op == OP_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        prod    = a_ext * b_ext;
        mul_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
`else
    assign mul_res = '0;
`endif

    // results that need no iteration: multiply, divide-by-zero, signed overflow
    always_comb begin
        fast_res = mul_res;
        if (is_div) begin
            if (div_zero) fast_res = is_rem ? a : '1;
            else          fast_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    muldiv_div_core u_div_core (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .start_i    (div_start),
        .step_i     ((state_q == S_BUSY) & ~fast_q),
        .dividend_i (mag_a),
        .divisor_i  (mag_b),
        .quot_o     (quot),
        .rem_o      (rem),
        .last_o     (div_last)
    );

    assign quot_fix = neg_q_q ? -quot : quot;
    assign rem_fix  = neg_r_q ? -rem  : rem;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)                state_d = S_BUSY;
            S_BUSY:  if (fast_q || div_last)    state_d = S_DONE;
            S_DONE:  if (bus.ready_i)           state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            result_q <= '0;
            rd_q     <= '0;
            fast_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_rem_q <= 1'b0;
        end else if (accept) begin
            rd_q     <= bus.rd_i;
            fast_q   <= ~div_start;
            neg_q_q  <= sign_a ^ sign_b;
            neg_r_q  <= sign_a;
            is_rem_q <= is_rem;
            if (!div_start) result_q <= fast_res;
        end else if (state_q == S_BUSY && !fast_q && div_last) begin
            result_q <= is_rem_q ? rem_fix : quot_fix;
        end
    end

    assign valid          = (state_q == S_DONE);
    assign bus.ready_o    = (state_q == S_IDLE);
    assign bus.valid_o    = valid;
    assign bus.result_o   = result_q;
    assign bus.rd_o       = rd_q;
    assign bus.regwrite_o = valid & bus.ready_i & (rd_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, stall/retire and reset sequences, random ops vs.
// an arithmetic reference model. Multiply expectations follow MULDIV_MUL_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_if bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a}; ua = {32'b0, a};
        sb = {{32{b[31]}}, b}; ub = {32'b0, b};
        ia = a; ib = b;
        p  = 64'd0;
        if (!op[2]) begin
`ifdef MULDIV_MUL_EN
            case (op)
                3'b000: begin p = ua * ub; return p[31:0];  end
                3'b001: begin p = sa * sb; return p[63:32]; end
                3'b010: begin p = sa * ub; return p[63:32]; end
                default: begin p = ua * ub; return p[63:32]; end
            endcase
`else
            return 32'd0;
`endif
        end
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            3'b100:  return ia / ib;
            3'b101:  return a / b;
            3'b110:  return ia % ib;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2] || b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string name);
        @(negedge clk);
        check({name, "_ready_before"}, 32'(bus.ready_o), 32'd1);
        bus.valid_i = 1'b1; bus.op_i = op; bus.operandA_i = a; bus.operandB_i = b; bus.rd_i = rd;
        @(posedge clk);
        #1 bus.valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.valid_o) begin lat = c; break; end
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                          input string name);
        int lat;
        issue(op, a, b, rd, name);
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, bus.result_o, exp);
        check({name, "_rd"}, 32'(bus.rd_o), 32'(rd));
        check({name, "_ready_in_done"}, 32'(bus.ready_o), 32'd0);
        bus.ready_i = 1'b1;
        #1 check({name, "_regwrite"}, 32'(bus.regwrite_o), 32'(rd != 5'd0));
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        check({name, "_valid_after_retire"}, 32'(bus.valid_o), 32'd0);
        check({name, "_ready_after_retire"}, 32'(bus.ready_o), 32'd1);
    endtask

    initial begin
        int lat;
        logic seen_valid;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;

        bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.op_i = 3'd0;
        bus.operandA_i = 32'd0; bus.operandB_i = 32'd0; bus.rd_i = 5'd0;

        #12;
        check("reset_ready",    32'(bus.ready_o),    32'd1);
        check("reset_valid",    32'(bus.valid_o),    32'd0);
        check("reset_result",   bus.result_o,        32'd0);
        check("reset_rd",       32'(bus.rd_o),       32'd0);
        check("reset_regwrite", 32'(bus.regwrite_o), 32'd0);
        @(negedge clk) rst = 1'b0;

        tv.push_back(mk(3'b100, 32'd100,        32'd7,          5'd1,  32'd14,         32));
        tv.push_back(mk(3'b110, 32'd100,        32'd7,          5'd2,  32'd2,          32));
        tv.push_back(mk(3'b100, 32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  32));
        tv.push_back(mk(3'b110, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  32));
        tv.push_back(mk(3'b101, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'h7FFF_FFFC,  32));
        tv.push_back(mk(3'b101, 32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF,  1));
        tv.push_back(mk(3'b111, 32'd5,          32'd0,          5'd7,  32'd5,          1));
        tv.push_back(mk(3'b110, 32'hFFFF_FFF9,  32'd0,          5'd8,  32'hFFFF_FFF9,  1));
        tv.push_back(mk(3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1));
        tv.push_back(mk(3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1));
        tv.push_back(mk(3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          32));
`ifdef MULDIV_MUL_EN
        tv.push_back(mk(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd12, 32'hFFFF_FFFE,  1));
        tv.push_back(mk(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd13, 32'd0,          1));
        tv.push_back(mk(3'b000, 32'd3,          32'hFFFF_FFFC,  5'd14, 32'hFFFF_FFF4,  1));
        tv.push_back(mk(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd15, 32'hFFFF_FFFF,  1));
`else
        tv.push_back(mk(3'b000, 32'd3,          32'hFFFF_FFFC,  5'd14, 32'd0,          1));
        tv.push_back(mk(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd12, 32'd0,          1));
`endif
        foreach (tv[i])
            run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].rd, tv[i].exp, tv[i].lat, $sformatf("tv%0d", i));

        // writeback stall with rd=0, ignored requests, then a request held through the retire cycle
        issue(3'b100, 32'd100, 32'd7, 5'd0, "stall");
        wait_valid(lat);
        check("stall_latency", 32'(lat), 32'd32);
        for (int k = 0; k < 10; k++) begin
            bus.valid_i = k[0]; bus.op_i = 3'b101; bus.operandA_i = 32'd1;
            bus.operandB_i = 32'd1; bus.rd_i = 5'd9;
            @(posedge clk); #1;
            check($sformatf("stall%0d_result", k),   bus.result_o,        32'd14);
            check($sformatf("stall%0d_rd", k),       32'(bus.rd_o),       32'd0);
            check($sformatf("stall%0d_ready", k),    32'(bus.ready_o),    32'd0);
            check($sformatf("stall%0d_valid", k),    32'(bus.valid_o),    32'd1);
            check($sformatf("stall%0d_regwrite", k), 32'(bus.regwrite_o), 32'd0);
        end
        bus.valid_i = 1'b1; bus.op_i = 3'b101; bus.operandA_i = 32'd5;
        bus.operandB_i = 32'd0; bus.rd_i = 5'd3;
        bus.ready_i = 1'b1;
        #1 check("stall_retire_regwrite", 32'(bus.regwrite_o), 32'd0);
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        check("retire_no_accept_valid", 32'(bus.valid_o), 32'd0);
        check("retire_no_accept_ready", 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check("next_cycle_accept_ready", 32'(bus.ready_o), 32'd0);
        wait_valid(lat);
        check("post_retire_latency", 32'(lat), 32'd1);
        check("post_retire_result", bus.result_o, 32'hFFFF_FFFF);
        check("post_retire_rd", 32'(bus.rd_o), 32'd3);
        bus.ready_i = 1'b1;
        #1 check("post_retire_regwrite", 32'(bus.regwrite_o), 32'd1);
        @(posedge clk); #1;
        bus.ready_i = 1'b0;

        // asynchronous reset in the middle of a division
        issue(3'b100, 32'd1000, 32'd3, 5'd7, "rst");
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midbusy_reset_valid",    32'(bus.valid_o),    32'd0);
        check("midbusy_reset_ready",    32'(bus.ready_o),    32'd1);
        check("midbusy_reset_result",   bus.result_o,        32'd0);
        check("midbusy_reset_rd",       32'(bus.rd_o),       32'd0);
        check("midbusy_reset_regwrite", 32'(bus.regwrite_o), 32'd0);
        @(negedge clk) rst = 1'b0;
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.valid_o) seen_valid = 1'b1;
        end
        check("discarded_op_no_result", 32'(seen_valid), 32'd0);
        run_op(3'b100, 32'd1000, 32'd3, 5'd7, 32'd333, 32, "after_reset");

        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = b >> $urandom_range(8, 31);
                default: ;
            endcase
            run_op(op, a, b, rd, model(op, a, b), model_lat(op, a, b), $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: valid_i  input  1  request valid.
REQ-005 SHALL have port: ready_o  output  1  unit can accept a request.
REQ-006 SHALL have port: op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port: operandA_i  input  32  rs1 value from the register file.
REQ-008 SHALL have port: operandB_i  input  32  rs2 value from the register file.
REQ-009 SHALL have port: rd_i  input  5  destination register index.
REQ-010 SHALL have port: valid_o  output  1  result valid.
REQ-011 SHALL have port: ready_i  input  1  writeback accepts the result.
REQ-012 SHALL have port: result_o  output  32  write data for the register file.
REQ-013 SHALL have port: rd_o  output  5  destination index for the register file.
REQ-014 SHALL have port: regwrite_o  output  1  register-file write enable.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE; ready_o = (state==IDLE).
REQ-016 SHALL accept a request when valid_i & ready_o at rising edge T0, capturing op_i, both operands and rd_i.
REQ-017 SHALL ignore valid_i in BUSY and DONE: no capture, no state change.
REQ-018 SHALL route DIV/DIVU/REM/REMU with nonzero divisor and no signed overflow IDLE->BUSY, then run one restoring-division iteration per cycle on operand magnitudes (signed ops) or raw values (unsigned), counted by a 5-bit counter.
REQ-019 SHALL enter DONE at edge T0+32 with sign-corrected result registered: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
REQ-020 SHALL handle divisor==0 as IDLE->DONE at T0+1: quotient 0xFFFFFFFF, remainder = dividend (signed and unsigned).
REQ-021 SHALL handle signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only) as IDLE->DONE at T0+1: quotient 0x80000000, remainder 0.
REQ-022 SHALL hold valid_o=1 in DONE, with result_o and rd_o stable until valid_o & ready_i, then go to IDLE on that edge.
REQ-023 SHALL drive regwrite_o = valid_o & ready_i & (rd_o != 0); rd_o==0 completes the handshake without a write.
REQ-024 SHALL NOT accept a new request in the cycle DONE retires; the next accept is possible one cycle later.

Reset
REQ-025 SHALL on reset_i=1 (any state, including mid-BUSY) immediately force IDLE, valid_o=0, result_o=0, rd_o=0, regwrite_o=0, counter=0, ready_o=1.
REQ-026 SHALL discard any in-flight operation on reset; no result is produced for it.

Configuration
REQ-027 SHALL, with MULDIV_MUL_EN defined, execute MUL/MULH/MULHSU/MULHU as IDLE->DONE at T0+1 with the registered 64-bit product: low word for MUL, high word for the others with the signedness per funct3.
REQ-028 SHALL, without MULDIV_MUL_EN, complete multiply ops at T0+1 with result_o=0 and include no multiplier logic.

Structure
REQ-029 SHALL place the op-code enum, the FSM state enum and the XLEN constant in shared package muldiv_pkg.
REQ-030 SHALL isolate the iterative divide datapath (partial remainder, quotient shift, counter) in sub-module muldiv_div_core.

Verification
REQ-031 SHALL cover: DIV 100/7 accepted at T0 -> valid_o at T0+32, result 14; REM same operands -> 2.
REQ-032 SHALL cover: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
REQ-033 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF at T0+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both at T0+1.
REQ-034 SHALL cover: ready_i=0 for 10 cycles in DONE -> result_o/rd_o stable, ready_o=0, valid_i pulses ignored; rd=0 -> regwrite_o never asserted.
REQ-035 SHALL cover: reset_i pulsed at BUSY cycle 10 -> valid_o=0, ready_o=1 without waiting for a clock edge; a fresh DIV afterwards is correct.
REQ-036 SHALL cover, with MULDIV_MUL_EN: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0; MUL 3*-4 -> 0xFFFFFFF4; without the macro, MUL -> 0 at T0+1.
